window_prob_decode: RTL and testbench

//  Receive-side partner of the window bit-insertion stage: consumes a unipolar stochastic bitstream
//  one bit per enabled cycle and, per window of iWindow bits, counts ones, then reports the

---
 rtl/window_prob_decode_pkg.sv | 16 +
 rtl/window_prob_decode_sc_window_cnt.sv | 30 +++
 rtl/window_prob_decode.sv | 83 ++++++++
 tb/tb_window_prob_decode.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/window_prob_decode_pkg.sv
// rtl/window_prob_decode_pkg.sv - shared stochastic-probability format helpers
package window_prob_decode_pkg;

  localparam int SC_BITWIDTH_DEF  = 8;
  localparam int SC_FBITWIDTH_DEF = 4;

  // 1.0 and 0.5 in the inserter's iProb fixed-point format
  function automatic int sc_one(input int fbw);
    return 1 << (fbw - 1);
  endfunction

  function automatic int sc_half(input int fbw);
    return 1 << (fbw - 2);
  endfunction

endpackage

// File: rtl/window_prob_decode_sc_window_cnt.sv
// rtl/window_prob_decode_sc_window_cnt.sv - window bit-index counter with last-bit flag
module sc_window_cnt #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iClr,
  input  logic                iEn,
  input  logic [BITWIDTH-1:0] iWindow,
  output logic                oLast
);

  logic [BITWIDTH-1:0] idx;
  logic [BITWIDTH-1:0] last_idx;

  // a zero-length window behaves as a one-bit window
  assign last_idx = (iWindow == '0) ? '0 : iWindow - BITWIDTH'(1);
  assign oLast    = (idx == last_idx);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      idx <= '0;
    end else if (iClr) begin
      idx <= '0;
    end else if (iEn) begin
      idx <= oLast ? '0 : idx + BITWIDTH'(1);
    end
  end

endmodule

// File: rtl/window_prob_decode.sv
// rtl/window_prob_decode.sv - per-window ones count to probability with valid/ready result
module window_prob_decode
  import window_prob_decode_pkg::*;
#(
  parameter int BITWIDTH  = SC_BITWIDTH_DEF,
  parameter int FBITWIDTH = SC_FBITWIDTH_DEF
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iClr,
  input  logic                 iEn,
  input  logic [BITWIDTH-1:0]  iWindow,
  input  logic [BITWIDTH-1:0]  iWINLOG2,
  input  logic                 iA,
  input  logic                 iReady,
  output logic [FBITWIDTH-1:0] oProb,
  output logic [BITWIDTH:0]    oCnt,
  output logic [BITWIDTH:0]    oDelta,
  output logic                 oPolarity,
  output logic                 oValid,
  output logic                 oOvf
);

  logic                          last;
  logic                          complete;
  logic [BITWIDTH-1:0]           ones;
  logic [BITWIDTH:0]             sum;
  logic [BITWIDTH+FBITWIDTH-1:0] prob_wide;
  logic [FBITWIDTH-1:0]          prob_next;
  logic [BITWIDTH:0]             delta_next;

  sc_window_cnt #(.BITWIDTH(BITWIDTH)) u_window_cnt (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iClr    (iClr),
    .iEn     (iEn),
    .iWindow (iWindow),
    .oLast   (last)
  );

  assign complete   = iEn && last && !iClr;
  assign sum        = {1'b0, ones} + (BITWIDTH+1)'(iA);
  // window is a power of two, so divide-by-window is a right shift by its log2
  assign prob_wide  = ((BITWIDTH+FBITWIDTH)'(sum) << (FBITWIDTH-1)) >> iWINLOG2;
  assign prob_next  = prob_wide[FBITWIDTH-1:0];
  assign delta_next = sum - {2'b00, iWindow[BITWIDTH-1:1]};

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      ones      <= '0;
      oProb     <= '0;
      oCnt      <= '0;
      oDelta    <= '0;
      oPolarity <= 1'b0;
      oValid    <= 1'b0;
      oOvf      <= 1'b0;
    end else if (iClr) begin
      ones   <= '0;
      oValid <= 1'b0;
      oOvf   <= 1'b0;
    end else begin
      if (iEn) begin
        if (last) begin
          ones      <= '0;
          oCnt      <= sum;
          oProb     <= prob_next;
          oDelta    <= delta_next;
          oPolarity <= (prob_next < FBITWIDTH'(sc_half(FBITWIDTH)));
        end else begin
          ones <= ones + BITWIDTH'(iA);
        end
      end
      // a new result always wins; losing an unconsumed one is flagged
      if (complete) begin
        oValid <= 1'b1;
        if (oValid && !iReady) oOvf <= 1'b1;
      end else if (oValid && iReady) begin
        oValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_prob_decode.sv
// tb/tb_window_prob_decode.sv - self-checking bench for window_prob_decode
module tb_window_prob_decode;
  localparam int BW  = 8;
  localparam int FBW = 4;

  logic           iClk = 1'b0;
  logic           iRstN, iClr, iEn, iA, iReady;
  logic [BW-1:0]  iWindow, iWINLOG2;
  logic [FBW-1:0] oProb;
  logic [BW:0]    oCnt, oDelta;
  logic           oPolarity, oValid, oOvf;

  int npass = 0;
  int ntot  = 0;

  always #5 iClk = ~iClk;

  window_prob_decode #(.BITWIDTH(BW), .FBITWIDTH(FBW)) dut (
    .iClk(iClk), .iRstN(iRstN), .iClr(iClr), .iEn(iEn), .iWindow(iWindow),
    .iWINLOG2(iWINLOG2), .iA(iA), .iReady(iReady), .oProb(oProb), .oCnt(oCnt),
    .oDelta(oDelta), .oPolarity(oPolarity), .oValid(oValid), .oOvf(oOvf)
  );

  typedef struct {
    int n; int lg; int ones;
    int cnt; int prob; int delta; int pol;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clk(input logic en, input logic a);
    iEn = en; iA = a;
    @(posedge iClk); #1;
  endtask

  task automatic clr_pulse();
    iClr = 1'b1; clk(1'b0, 1'b0); iClr = 1'b0;
  endtask

  task automatic chk_res(input string name, input int cnt, input int prob, input int delta, input int pol);
    chk({name, ".cnt"},   int'(oCnt), cnt);
    chk({name, ".prob"},  int'(oProb), prob);
    chk({name, ".delta"}, int'($signed(oDelta)), delta);
    chk({name, ".pol"},   int'(oPolarity), pol);
  endtask

  vec_t vecs[10];

  // reference model state
  bit q[$];
  int m_n, m_cnt, m_prob, m_delta, m_pol, m_valid, m_ovf;

  initial begin
    vecs[0] = '{16, 4, 16, 16, 8,  8, 0};
    vecs[1] = '{16, 4,  8,  8, 4,  0, 0};
    vecs[2] = '{16, 4,  4,  4, 2, -4, 1};
    vecs[3] = '{16, 4,  0,  0, 0, -8, 1};
    vecs[4] = '{ 8, 3,  3,  3, 3, -1, 1};
    vecs[5] = '{ 4, 2,  3,  3, 6,  1, 0};
    vecs[6] = '{ 1, 0,  1,  1, 8,  1, 0};
    vecs[7] = '{ 2, 1,  1,  1, 4,  0, 0};
    vecs[8] = '{32, 5, 31, 31, 7, 15, 0};
    vecs[9] = '{128, 7, 100, 100, 6, 36, 0};

    iRstN = 1'b0; iClr = 1'b0; iEn = 1'b0; iA = 1'b0; iReady = 1'b1;
    iWindow = 8'd16; iWINLOG2 = 8'd4;
    #12;
    chk("reset.valid", int'(oValid), 0);
    chk("reset.ovf", int'(oOvf), 0);
    chk_res("reset", 0, 0, 0, 0);
    @(posedge iClk); #1; iRstN = 1'b1;

    foreach (vecs[k]) begin
      iWindow = BW'(vecs[k].n); iWINLOG2 = BW'(vecs[k].lg);
      clr_pulse();
      for (int i = 0; i < vecs[k].n; i++) begin
        if (i == vecs[k].n - 1) chk($sformatf("v%0d.pre_valid", k), int'(oValid), 0);
        clk(1'b1, i < vecs[k].ones);
      end
      chk($sformatf("v%0d.valid", k), int'(oValid), 1);
      chk_res($sformatf("v%0d", k), vecs[k].cnt, vecs[k].prob, vecs[k].delta, vecs[k].pol);
      clk(1'b0, 1'b0);
      chk($sformatf("v%0d.consumed", k), int'(oValid), 0);
    end

    // two windows unconsumed -> overwrite flagged
    iWindow = 8'd16; iWINLOG2 = 8'd4; clr_pulse();
    iReady = 1'b0;
    for (int i = 0; i < 16; i++) clk(1'b1, i < 3);
    chk("ovf.first_valid", int'(oValid), 1);
    chk("ovf.first_ovf", int'(oOvf), 0);
    chk("ovf.first_cnt", int'(oCnt), 3);
    for (int i = 0; i < 16; i++) clk(1'b1, i < 5);
    chk("ovf.ovf", int'(oOvf), 1);
    chk("ovf.cnt", int'(oCnt), 5);
    chk("ovf.valid", int'(oValid), 1);
    iReady = 1'b1; clk(1'b0, 1'b0);
    chk("ovf.consume", int'(oValid), 0);
    chk("ovf.sticky", int'(oOvf), 1);
    clr_pulse();
    chk("ovf.clr", int'(oOvf), 0);

    // stall mid-window
    for (int i = 0; i < 8; i++) clk(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      clk(1'b0, 1'b0);
      chk("stall.hold_valid", int'(oValid), 0);
    end
    for (int i = 0; i < 7; i++) clk(1'b1, 1'b1);
    chk("stall.not_yet", int'(oValid), 0);
    clk(1'b1, 1'b1);
    chk("stall.valid", int'(oValid), 1);
    chk_res("stall", 16, 8, 8, 0);

    // async reset mid-window discards partial count
    for (int i = 0; i < 7; i++) clk(1'b1, 1'b1);
    iRstN = 1'b0; #1;
    chk("rst.valid", int'(oValid), 0);
    chk_res("rst", 0, 0, 0, 0);
    @(posedge iClk); #1; iRstN = 1'b1;
    for (int i = 0; i < 16; i++) clk(1'b1, 1'b1);
    chk("rst.valid_after", int'(oValid), 1);
    chk_res("rst.after", 16, 8, 8, 0);

    // randomized run against a window-level model
    m_cnt = 16; m_prob = 8; m_delta = 8; m_pol = 0; m_valid = 1; m_ovf = 0;
    m_n = 16;
    for (int c = 0; c < 1500; c++) begin
      bit en, a, rdy, done;
      int s;
      if (q.size() == 0) begin
        int lg;
        lg = $urandom_range(2, 5);
        m_n = 1 << lg;
        iWindow = BW'(m_n); iWINLOG2 = BW'(lg);
      end
      en  = ($urandom_range(0, 3) != 0);
      a   = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 2) != 0);
      iReady = rdy;
      done = 1'b0;
      if (en) begin
        q.push_back(a);
        if (q.size() == m_n) begin
          done = 1'b1;
          s = 0;
          foreach (q[j]) s += int'(q[j]);
          q.delete();
          m_cnt = s;
          m_prob = (s * (1 << (FBW - 1))) / m_n;
          m_delta = s - m_n / 2;
          m_pol = (m_prob < (1 << (FBW - 2))) ? 1 : 0;
        end
      end
      if (done) begin
        if (m_valid == 1 && !rdy) m_ovf = 1;
        m_valid = 1;
      end else if (m_valid == 1 && rdy) begin
        m_valid = 0;
      end
      clk(en, a);
      chk("rnd.valid", int'(oValid), m_valid);
      chk("rnd.ovf", int'(oOvf), m_ovf);
      chk_res("rnd", m_cnt, m_prob, m_delta, m_pol);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
